// File: rtl/data_mem_responder.sv
// Wait-stated 16x8 data memory answering the accumulator CPU's read/write strobes.
// Each access runs IDLE -> BUSY (WAIT_STATES+1 cycles) -> DONE and ends in a one-cycle memReady pulse.
module data_mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mReadFlag,
  input  logic              mWriteFlag,
  input  logic [ADDR_W-1:0] dataMemAddrBus,
  input  logic [DATA_W-1:0] dataMemInDataBus,
  output logic [DATA_W-1:0] dataMemOutDataBus,
  output logic              memReady,
  output logic              memBusy,
  output logic              memErr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]        stateReg, stateNext;
  logic [3:0]        countReg, countNext;
  logic              opWriteReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] dataReg;
  logic [DATA_W-1:0] memArray [DEPTH];
  logic [DEPTH-1:0]  wordWe;
  logic              singleReq, bothReq, accessNow;

  assign singleReq = mReadFlag ^ mWriteFlag;
  assign bothReq   = mReadFlag & mWriteFlag;
  // The access itself happens on the last BUSY edge, when the wait counter has run out.
  assign accessNow = (stateReg == BUSY) && (countReg == 4'd0);
  assign memBusy   = (stateReg == BUSY) || (stateReg == DONE);

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    case (stateReg)
      IDLE: begin
        if (singleReq) begin
          stateNext = BUSY;
          countNext = WAIT_LOAD;
        end
      end
      BUSY: begin
        if (countReg == 4'd0) stateNext = DONE;
        else                  countNext = countReg - 4'd1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg          <= IDLE;
      countReg          <= 4'd0;
      opWriteReg        <= 1'b0;
      addrReg           <= '0;
      dataReg           <= '0;
      dataMemOutDataBus <= '0;
      memReady          <= 1'b0;
      memErr            <= 1'b0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      memReady <= accessNow;
      memErr   <= (stateReg == IDLE) && bothReq;
      // Bus contents are captured only at the sampling edge; later bus activity is ignored.
      if ((stateReg == IDLE) && singleReq) begin
        opWriteReg <= mWriteFlag;
        addrReg    <= dataMemAddrBus;
        dataReg    <= dataMemInDataBus;
      end
      if (accessNow && !opWriteReg) dataMemOutDataBus <= memArray[addrReg];
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign wordWe[gi] = accessNow && opWriteReg && (addrReg == ADDR_W'(gi));
    end
  endgenerate

  // Reset must clear every word, so the store is a register file rather than block RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) memArray[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wordWe[i]) memArray[i] <= dataReg;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a driver pushes expected strobes, a monitor pops and checks them.
module tb_data_mem_responder;
  parameter int WS = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       mReadFlag, mWriteFlag;
  logic [3:0] dataMemAddrBus;
  logic [7:0] dataMemInDataBus;
  logic [7:0] dataMemOutDataBus;
  logic       memReady, memBusy, memErr;

  data_mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .mReadFlag(mReadFlag), .mWriteFlag(mWriteFlag),
    .dataMemAddrBus(dataMemAddrBus), .dataMemInDataBus(dataMemInDataBus),
    .dataMemOutDataBus(dataMemOutDataBus), .memReady(memReady), .memBusy(memBusy), .memErr(memErr)
  );

  always #5 clock = ~clock;

  int edgeCnt = 0;
  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  // kind: 0 read completion, 1 write completion, 2 rejected request
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         edgeAt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[16];
  logic [7:0] heldRead;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    heldRead = 8'h00;
  endtask

  // Issue one request; with intrude set, a write to addr 9 is waved at the DUT throughout BUSY.
  task automatic issue(input bit rd, input bit wr, input int addr, input logic [7:0] d, input bit intrude);
    exp_t it;
    int   e;
    @(negedge clock);
    e = edgeCnt;
    if (rd && wr) begin
      it.kind = 2; it.data = heldRead; it.edgeAt = e + 1;
    end else if (wr) begin
      model[addr] = d;
      it.kind = 1; it.data = heldRead; it.edgeAt = e + 2 + WS;
    end else begin
      heldRead = model[addr];
      it.kind = 0; it.data = heldRead; it.edgeAt = e + 2 + WS;
    end
    sb.push_back(it);
    $display("[TB] req rd=%0d wr=%0d addr=%0d data=%02h expect=%02h", rd, wr, addr, d, it.data);
    mReadFlag = rd; mWriteFlag = wr;
    dataMemAddrBus = 4'(addr); dataMemInDataBus = d;
    @(negedge clock);
    if (intrude) begin
      mReadFlag = 1'b0; mWriteFlag = 1'b1;
      dataMemAddrBus = 4'd9; dataMemInDataBus = 8'h77;
      repeat (WS + 1) @(negedge clock);
    end
    mReadFlag = 1'b0; mWriteFlag = 1'b0;
    dataMemAddrBus = 4'(($urandom));
    dataMemInDataBus = 8'($urandom);
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
    check("idle_busy", memBusy, 0);
    check("idle_hold", dataMemOutDataBus, heldRead);
  endtask

  // Monitor: every ready/err pulse must match the head of the scoreboard.
  initial begin
    exp_t it;
    int   busyRun = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busyRun = 0;
      end else begin
        if (memBusy) busyRun++;
        else         busyRun = 0;
        if (memReady || memErr) begin
          if (sb.size() == 0) begin
            check("unexpected_strobe", {memErr, memReady}, 0);
          end else begin
            it = sb.pop_front();
            check("strobe_kind", {memErr, memReady}, (it.kind == 2) ? 2 : 1);
            check("strobe_edge", edgeCnt, it.edgeAt);
            check("read_data", dataMemOutDataBus, it.data);
            if (it.kind == 2) check("err_busy", memBusy, 0);
            else              check("busy_cycles", busyRun, WS + 2);
            $display("[TB] done kind=%0d edge=%0d data=%02h", it.kind, edgeCnt, dataMemOutDataBus);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mReadFlag = 1'b0; mWriteFlag = 1'b0;
    dataMemAddrBus = 4'd0; dataMemInDataBus = 8'h00;
    modelReset();
    repeat (3) @(negedge clock);
    check("rst_out", dataMemOutDataBus, 0);
    check("rst_ready", memReady, 0);
    check("rst_busy", memBusy, 0);
    check("rst_err", memErr, 0);
    reset = 1'b0;

    // Reset mid-BUSY during a write: nothing committed, outputs cleared at once.
    @(negedge clock);
    mWriteFlag = 1'b1; dataMemAddrBus = 4'd3; dataMemInDataBus = 8'hA5;
    @(negedge clock);
    mWriteFlag = 1'b0;
    check("pre_abort_busy", memBusy, 1);
    reset = 1'b1;
    #1;
    check("abort_out", dataMemOutDataBus, 0);
    check("abort_ready", memReady, 0);
    check("abort_busy", memBusy, 0);
    check("abort_err", memErr, 0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    issue(1, 0, 3, 8'h00, 0); waitIdle();

    // Write then read back.
    issue(0, 1, 7, 8'h3C, 0); waitIdle();
    issue(1, 0, 7, 8'h00, 0); waitIdle();
    issue(0, 1, 0, 8'hFF, 0); waitIdle();
    issue(1, 0, 0, 8'h00, 0); waitIdle();

    // Collision leaves memory alone.
    issue(1, 1, 2, 8'h11, 0); waitIdle();
    issue(1, 0, 2, 8'h00, 0); waitIdle();

    // Bus activity while busy is ignored.
    issue(0, 1, 1, 8'h5A, 0); waitIdle();
    issue(1, 0, 1, 8'h00, 1); waitIdle();
    issue(1, 0, 9, 8'h00, 0); waitIdle();

    // Boundary addresses and read-data hold across a write.
    issue(0, 1, 15, 8'h80, 0); waitIdle();
    issue(0, 1, 0, 8'h01, 0); waitIdle();
    issue(1, 0, 15, 8'h00, 0); waitIdle();
    issue(0, 1, 0, 8'h55, 0); waitIdle();
    repeat (3) @(negedge clock);
    check("hold_after_write", dataMemOutDataBus, 8'h80);

    // Randomized traffic against the array model.
    for (int n = 0; n < 60; n++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op == 0)      issue(1, 1, $urandom_range(0, 15), 8'($urandom), 0);
      else if (op < 4)  issue(0, 1, $urandom_range(0, 15), 8'($urandom), 0);
      else              issue(1, 0, $urandom_range(0, 15), 8'h00, op == 7);
      waitIdle();
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    waitIdle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the accumulator CPU data bus. It answers the CPU's mReadFlag/mWriteFlag strobes, 4-bit address and 8-bit write bus.
- Holds a 16x8 register-file data memory with a programmable wait-state counter.
- Signals completion with a one-cycle ready pulse, so the CPU control unit can stall on slow memory.
- Sits between the CPU core and the data store, replacing a purely combinational memory.

Parameters:
- DATA_W, 8, data word width
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16
- WAIT_STATES, 1, extra busy cycles per access; legal 0..15

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and memory
- mReadFlag  in  1  read request from CPU
- mWriteFlag  in  1  write request from CPU
- dataMemAddrBus  in  ADDR_W  access address
- dataMemInDataBus  in  DATA_W  write data from CPU
- dataMemOutDataBus  out  DATA_W  read data to CPU (registered)
- memReady  out  1  one-cycle completion pulse
- memBusy  out  1  high while an access is in flight (BUSY or DONE)
- memErr  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, active-high):
  - State = IDLE, counter = 0.
  - All 16 words = 8'h00.
  - dataMemOutDataBus = 8'h00; memReady, memBusy, memErr = 0.
- Reset asserted mid-access aborts the access immediately. A pending write is NOT committed.
- FSM states:
  - IDLE:
    - Exactly one of mReadFlag/mWriteFlag high at a clock edge: latch op, address and write data; load counter = WAIT_STATES; go to BUSY.
    - Both flags high: no access, memErr pulses for the following cycle, stay IDLE.
    - Neither flag high: stay IDLE.
  - BUSY:
    - Counter nonzero: decrement.
    - Counter zero: perform the access, assert memReady for the next cycle, go to DONE.
      - Write: mem[latched addr] <= latched data.
      - Read: dataMemOutDataBus <= mem[latched addr].
  - DONE: memReady = 1 for exactly this cycle; flags ignored; next edge goes to IDLE.
- Latency:
  - Request sampled at edge N; memReady high during the cycle after edge N+1+WAIT_STATES.
  - WAIT_STATES = 0 gives ready in the cycle after edge N+1.
  - Minimum spacing between sampled requests is WAIT_STATES+3 edges.
- Request latching:
  - Address and write data are latched at the sampling edge.
  - Bus changes during BUSY/DONE have no effect.
  - Flags seen during BUSY/DONE are ignored and never queued.
- Read data:
  - Updated only on read completion.
  - Held stable across writes and idle cycles until the next read completes.
  - A read of an address written by the immediately preceding access returns the new value.
- memBusy = 1 in BUSY and DONE, 0 in IDLE.
- Address wrap: the full 4-bit range 0..15 is valid; no out-of-range case exists.
- No combinational path from inputs to any output; all outputs are registered or decoded from state.

Test Plan:
- Reset check: assert reset mid-BUSY during a write of 8'hA5 to addr 3 → all outputs 0 immediately; after release, a read of addr 3 returns 8'h00 and memReady pulses once.
- Write then read, WAIT_STATES=1: write 8'h3C to addr 7 (sampled edge N) → memReady high after edge N+2 only. Read addr 7 → dataMemOutDataBus = 8'h3C coincident with memReady.
- WAIT_STATES=0 and WAIT_STATES=3 builds: read addr 0 after writing 8'hFF → memReady after edges N+1 and N+4 respectively; memBusy high for 2 and 5 cycles.
- Collision: mReadFlag=mWriteFlag=1 in IDLE with addr 2, data 8'h11 → memErr pulses one cycle; memReady stays 0; mem[2] unchanged (8'h00).
- Ignore-while-busy: start read of addr 1; during BUSY change address to 9 and pulse mWriteFlag with 8'h77 → read returns mem[1]; mem[9] remains 8'h00; exactly one memReady pulse.
- Boundary addresses and data hold: write 8'h80 to addr 15 and 8'h01 to addr 0, read addr 15 → 8'h80. Subsequent write to addr 0 leaves dataMemOutDataBus at 8'h80 until the next read.
